// File: rtl/regfile_2r1w_if.sv
// +--------------------------------------------------------------------------+
// | regfile_2r1w_if : write, read and scoreboard signals of regfile_2r1w     |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
`default_nettype none

interface regfile_2r1w_if #(
  parameter int DATA_W = 8,
  parameter int N_REGS = 4,
  parameter int ADDR_W = $clog2(N_REGS)
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              busy_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              busy_b;
  logic              pend_set;
  logic [ADDR_W-1:0] pend_addr;
  logic [N_REGS-1:0] pend_vec;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    input  rd_data_a, busy_a, rd_data_b, busy_b, pend_vec
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, pend_set, pend_addr,
    output rd_data_a, busy_a, rd_data_b, busy_b, pend_vec
  );
endinterface

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// +--------------------------------------------------------------------------+
// | regfile_2r1w : 2-read/1-write register file with write bypass and a      |
// | per-register pending scoreboard; optional registered reads. Rev 1.0      |
// +--------------------------------------------------------------------------+
`default_nettype none

module regfile_2r1w #(
  parameter int DATA_W       = 8,
  parameter int N_REGS       = 4,
  parameter int ADDR_W       = $clog2(N_REGS),
  parameter int ZERO_REG     = 0,
  parameter int READ_LATENCY = 0
) (
  input  logic           clk,
  input  logic           nReset,
  regfile_2r1w_if.slave  bus
);

  localparam logic [ADDR_W:0] c_n_regs = (ADDR_W + 1)'(N_REGS);

  logic [DATA_W-1:0] regs_q [N_REGS];
  logic [DATA_W-1:0] regs_d [N_REGS];
  logic [N_REGS-1:0] pend_q;
  logic [N_REGS-1:0] pend_d;
  logic              wr_ok;
  logic              pend_ok;
  logic [ADDR_W-1:0] rd_addr [2];

  // In range and not the hard-wired zero register.
  function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < c_n_regs) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  assign wr_ok   = bus.wr_en && addr_writable(bus.wr_addr);
  assign pend_ok = bus.pend_set && addr_writable(bus.pend_addr);

  assign rd_addr[0] = bus.rd_addr_a;
  assign rd_addr[1] = bus.rd_addr_b;

  // A write clears the pending bit; a same-cycle pend_set re-arms it.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int i = 0; i < N_REGS; i++) begin
      if (bus.wr_en && (bus.wr_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b0;
        if (wr_ok) begin
          regs_d[i] = bus.wr_data;
        end
      end
      if (pend_ok && (bus.pend_addr == ADDR_W'(i))) begin
        pend_d[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      regs_q <= '{default: '0};
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  assign bus.pend_vec = pend_q;

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [DATA_W-1:0] data_d;
    logic              busy_d;
    logic [DATA_W-1:0] data_out;
    logic              busy_out;

    // Out-of-range addresses match no entry and fall through to 0 / not busy.
    always_comb begin
      logic              pend_hit;
      logic              wr_hit;
      data_d   = '0;
      pend_hit = 1'b0;
      for (int i = 0; i < N_REGS; i++) begin
        if (rd_addr[p] == ADDR_W'(i)) begin
          data_d   = regs_q[i];
          pend_hit = pend_q[i];
        end
      end
      wr_hit = bus.wr_en && (bus.wr_addr == rd_addr[p]);
      if (wr_hit && wr_ok) begin
        data_d = bus.wr_data;
      end
      busy_d = pend_hit && !wr_hit;
    end

    if (READ_LATENCY == 1) begin : g_lat1
      logic [DATA_W-1:0] data_q;
      logic              busy_q;

      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          data_q <= '0;
          busy_q <= 1'b0;
        end else begin
          data_q <= data_d;
          busy_q <= busy_d;
        end
      end

      assign data_out = data_q;
      assign busy_out = busy_q;
    end else begin : g_lat0
      assign data_out = data_d;
      assign busy_out = busy_d;
    end
  end

  assign bus.rd_data_a = g_port[0].data_out;
  assign bus.busy_a    = g_port[0].busy_out;
  assign bus.rd_data_b = g_port[1].data_out;
  assign bus.busy_b    = g_port[1].busy_out;

endmodule

`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
// +--------------------------------------------------------------------------+
// | tb_regfile_2r1w : two regfile_2r1w configurations (comb/plain and        |
// | registered/zero-reg) driven alike, checked against an array model. 1.0  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regfile_2r1w;
  localparam int DW = 8;
  localparam int NR = 5;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  regfile_2r1w_if #(.DATA_W(DW), .N_REGS(NR)) bus0 ();
  regfile_2r1w_if #(.DATA_W(DW), .N_REGS(NR)) bus1 ();

  regfile_2r1w #(.DATA_W(DW), .N_REGS(NR), .ZERO_REG(0), .READ_LATENCY(0)) u_dut0 (
    .clk(clk), .nReset(nReset), .bus(bus0)
  );
  regfile_2r1w #(.DATA_W(DW), .N_REGS(NR), .ZERO_REG(1), .READ_LATENCY(1)) u_dut1 (
    .clk(clk), .nReset(nReset), .bus(bus1)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Model: config 0 = plain, config 1 = register 0 hard-wired to zero.
  logic [DW-1:0] mreg  [2][NR];
  logic [NR-1:0] mpend [2];

  typedef struct {
    int          cyc;
    logic [DW-1:0] da;
    logic [DW-1:0] db;
    logic        ba;
    logic        bb;
    logic [NR-1:0] p0;
    logic [NR-1:0] p1;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic writable(int c, int a);
    return (a < NR) && !(c == 1 && a == 0);
  endfunction

  function automatic logic [DW-1:0] mread(int c, int a, logic we, int wa, logic [DW-1:0] wd);
    if (a >= NR) return '0;
    if (we && wa == a && writable(c, a)) return wd;
    return mreg[c][a];
  endfunction

  function automatic logic mbusy(int c, int a, logic we, int wa);
    if (a >= NR) return 1'b0;
    return mpend[c][a] && !(we && wa == a);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      mpend[c] = '0;
      for (int i = 0; i < NR; i++) mreg[c][i] = '0;
    end
  endtask

  task automatic drive(logic we, int wa, logic [DW-1:0] wd, int ra, int rb, logic ps, int pa);
    bus0.wr_en = we;  bus0.wr_addr = AW'(wa); bus0.wr_data = wd;
    bus0.rd_addr_a = AW'(ra); bus0.rd_addr_b = AW'(rb);
    bus0.pend_set = ps; bus0.pend_addr = AW'(pa);
    bus1.wr_en = we;  bus1.wr_addr = AW'(wa); bus1.wr_data = wd;
    bus1.rd_addr_a = AW'(ra); bus1.rd_addr_b = AW'(rb);
    bus1.pend_set = ps; bus1.pend_addr = AW'(pa);
  endtask

  // One cycle of stimulus: expected responses are queued, then the model advances.
  task automatic step(logic we, int wa, logic [DW-1:0] wd, int ra, int rb, logic ps, int pa);
    exp_t e0;
    exp_t e1;
    @(posedge clk);
    #1;
    drive(we, wa, wd, ra, rb, ps, pa);
    e0.cyc = cyc;
    e0.da = mread(0, ra, we, wa, wd);  e0.db = mread(0, rb, we, wa, wd);
    e0.ba = mbusy(0, ra, we, wa);      e0.bb = mbusy(0, rb, we, wa);
    e0.p0 = mpend[0];                  e0.p1 = mpend[1];
    e1 = e0;
    e1.da = mread(1, ra, we, wa, wd);  e1.db = mread(1, rb, we, wa, wd);
    e1.ba = mbusy(1, ra, we, wa);      e1.bb = mbusy(1, rb, we, wa);
    q0.push_back(e0);
    q1.push_back(e1);
    for (int c = 0; c < 2; c++) begin
      if (we && writable(c, wa)) mreg[c][wa] = wd;
      if (we && wa < NR) mpend[c][wa] = 1'b0;
      if (ps && writable(c, pa)) mpend[c][pa] = 1'b1;
    end
  endtask

  // Combinational config: response is visible in the cycle it was issued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q0.size() > 0 && q0[0].cyc <= cyc) begin
        e = q0.pop_front();
        check("c0_rd_a",   32'(bus0.rd_data_a), 32'(e.da));
        check("c0_rd_b",   32'(bus0.rd_data_b), 32'(e.db));
        check("c0_busy_a", 32'(bus0.busy_a),    32'(e.ba));
        check("c0_busy_b", 32'(bus0.busy_b),    32'(e.bb));
        check("c0_pend",   32'(bus0.pend_vec),  32'(e.p0));
        check("c1_pend",   32'(bus1.pend_vec),  32'(e.p1));
      end
    end
  end

  // Registered config: response appears one edge later.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q1.size() > 0 && q1[0].cyc < cyc) begin
        e = q1.pop_front();
        check("c1_rd_a",   32'(bus1.rd_data_a), 32'(e.da));
        check("c1_rd_b",   32'(bus1.rd_data_b), 32'(e.db));
        check("c1_busy_a", 32'(bus1.busy_a),    32'(e.ba));
        check("c1_busy_b", 32'(bus1.busy_b),    32'(e.bb));
      end
    end
  end

  initial begin
    model_reset();
    drive(1'b0, 0, 8'h00, 0, 0, 1'b0, 0);

    // Reset state on every address, both ports.
    #2;
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 0, 8'h00, a, 7 - a, 1'b0, 0);
      #1;
      check("rst_c0_rd_a", 32'(bus0.rd_data_a), 32'h0);
      check("rst_c0_rd_b", 32'(bus0.rd_data_b), 32'h0);
      check("rst_c0_busy", 32'({bus0.busy_a, bus0.busy_b}), 32'h0);
      check("rst_c1_rd_a", 32'(bus1.rd_data_a), 32'h0);
      check("rst_c1_busy", 32'({bus1.busy_a, bus1.busy_b}), 32'h0);
      check("rst_pend",    32'({bus0.pend_vec, bus1.pend_vec}), 32'h0);
    end
    @(negedge clk);
    nReset = 1'b1;

    // Write reg2, then reset asynchronously mid-cycle; a write pending at reset is lost.
    step(1'b1, 2, 8'hA5, 2, 2, 1'b1, 3);
    step(1'b1, 2, 8'h5A, 2, 2, 1'b0, 0);
    #1;
    check("pre_rst_bypass", 32'(bus0.rd_data_a), 32'h5A);
    drive(1'b0, 0, 8'h00, 2, 3, 1'b0, 0);
    #1;
    check("pre_rst_reg2", 32'(bus0.rd_data_a), 32'hA5);
    drive(1'b1, 2, 8'h66, 2, 3, 1'b0, 0);
    nReset = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    #1;
    check("midrst_c0_reg2", 32'(bus0.rd_data_b), 32'h0);
    check("midrst_c1_reg2", 32'(bus1.rd_data_a), 32'h0);
    check("midrst_pend",    32'({bus0.pend_vec, bus1.pend_vec}), 32'h0);
    @(posedge clk);
    #1;
    drive(1'b0, 0, 8'h00, 2, 2, 1'b0, 0);
    @(negedge clk);
    nReset = 1'b1;
    step(1'b0, 0, 8'h00, 2, 3, 1'b0, 0);

    // Basic writes and reads, including address 4 and out-of-range 6.
    step(1'b1, 1, 8'h3C, 0, 0, 1'b0, 0);
    step(1'b1, 3, 8'hC3, 1, 3, 1'b0, 0);
    step(1'b0, 0, 8'h00, 1, 3, 1'b0, 0);
    step(1'b1, 4, 8'h9E, 4, 6, 1'b0, 0);
    step(1'b1, 6, 8'hEE, 4, 6, 1'b1, 6);
    step(1'b0, 0, 8'h00, 6, 4, 1'b0, 0);

    // Bypass to both ports at once.
    step(1'b1, 2, 8'h77, 2, 2, 1'b0, 0);
    step(1'b0, 0, 8'h00, 2, 2, 1'b0, 0);

    // Scoreboard set, clear by write, and set-wins-over-clear.
    step(1'b0, 0, 8'h00, 1, 2, 1'b1, 1);
    step(1'b0, 0, 8'h00, 1, 2, 1'b0, 0);
    step(1'b1, 1, 8'h10, 1, 1, 1'b0, 0);
    step(1'b0, 0, 8'h00, 1, 1, 1'b0, 0);
    step(1'b1, 1, 8'h20, 1, 0, 1'b1, 1);
    step(1'b0, 0, 8'h00, 1, 1, 1'b0, 0);

    // Register 0: writes and pend_set ignored only in the zero-reg config.
    step(1'b1, 0, 8'hFF, 0, 1, 1'b1, 0);
    step(1'b0, 0, 8'h00, 0, 1, 1'b0, 0);

    // Sweep read addresses to expose the one-cycle lag of registered reads.
    for (int a = 0; a < 4; a++) step(1'b0, 0, 8'h00, a, 3 - a, 1'b0, 0);

    for (int n = 0; n < 400; n++) begin
      int wa;
      int ra;
      int rb;
      wa = $urandom_range(0, 7);
      ra = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      rb = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, 7);
      step(1'($urandom_range(0, 1)), wa, 8'($urandom), ra, rb,
           ($urandom_range(0, 3) == 0), $urandom_range(0, 7));
    end

    step(1'b0, 0, 8'h00, 0, 1, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("drain_q0", 32'(q0.size()), 32'h0);
    check("drain_q1", 32'(q1.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
